// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin share of one barrel shifter between two requesters,
//               with ARM register-shift fixup (8-bit amount, carry, sign fill).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src,
    input  logic [7:0]  req0_amt,
    input  logic [1:0]  req0_sel,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src,
    input  logic [7:0]  req1_amt,
    input  logic [1:0]  req1_sel,
    input  logic        req1_cin,
    output logic [31:0] sh_source,
    output logic [4:0]  sh_amount,
    output logic [1:0]  sh_sel,
    input  logic [31:0] sh_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_id
);

    localparam logic [1:0] c_LSL = 2'b00;
    localparam logic [1:0] c_LSR = 2'b01;
    localparam logic [1:0] c_ASR = 2'b10;
    localparam logic [1:0] c_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr;
    logic [31:0] r_src;
    logic [7:0]  r_amt;
    logic [1:0]  r_sel;
    logic        r_cin;
    logic        r_id;
    logic [31:0] r_sh_source;
    logic [4:0]  r_sh_amount;
    logic [1:0]  r_sh_sel;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_result;
    logic        r_rsp_carry;
    logic        r_rsp_id;

    logic        w_grant;
    logic        w_hs;
    logic [31:0] w_in_src;
    logic [7:0]  w_in_amt;
    logic [1:0]  w_in_sel;
    logic        w_in_cin;
    logic        w_in_override;
    logic        w_big;
    logic        w_is32;
    logic [4:0]  w_a5;
    logic [31:0] w_fix_result;
    logic        w_fix_carry;

    assign w_grant    = (req0_valid & req1_valid) ? r_rr : req1_valid;
    assign req0_ready = ~reset & (r_state == S_IDLE) & req0_valid & ~w_grant;
    assign req1_ready = ~reset & (r_state == S_IDLE) & req1_valid &  w_grant;
    assign w_hs       = req0_ready | req1_ready;

    assign w_in_src = w_grant ? req1_src : req0_src;
    assign w_in_amt = w_grant ? req1_amt : req0_amt;
    assign w_in_sel = w_grant ? req1_sel : req0_sel;
    assign w_in_cin = w_grant ? req1_cin : req0_cin;

    // Cases fully resolved by the fixup run the shifter at amount 0.
    assign w_in_override = (w_in_amt == 8'd0)
                         | ((w_in_sel != c_ROR) & (|w_in_amt[7:5]))
                         | ((w_in_sel == c_ROR) & (w_in_amt[4:0] == 5'd0));

    assign w_big  = |r_amt[7:5];
    assign w_is32 = (r_amt == 8'd32);
    assign w_a5   = r_amt[4:0];

    always_comb begin
        w_fix_result = sh_result;
        w_fix_carry  = r_cin;
        if (r_amt == 8'd0) begin
            w_fix_result = r_src;
            w_fix_carry  = r_cin;
        end else begin
            case (r_sel)
                c_LSL: begin
                    if (w_big) begin
                        w_fix_result = 32'd0;
                        w_fix_carry  = w_is32 & r_src[0];
                    end else begin
                        w_fix_carry  = r_src[5'd0 - w_a5];
                    end
                end
                c_LSR: begin
                    if (w_big) begin
                        w_fix_result = 32'd0;
                        w_fix_carry  = w_is32 & r_src[31];
                    end else begin
                        w_fix_carry  = r_src[w_a5 - 5'd1];
                    end
                end
                c_ASR: begin
                    if (w_big) begin
                        w_fix_result = {32{r_src[31]}};
                        w_fix_carry  = r_src[31];
                    end else begin
                        w_fix_result = sh_result | (r_src[31] ? ~(32'hFFFF_FFFF >> w_a5) : 32'd0);
                        w_fix_carry  = r_src[w_a5 - 5'd1];
                    end
                end
                default: begin
                    if (w_a5 == 5'd0) begin
                        w_fix_result = r_src;
                        w_fix_carry  = r_src[31];
                    end else begin
                        w_fix_carry  = r_src[w_a5 - 5'd1];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr         <= RR_INIT;
            r_src        <= 32'd0;
            r_amt        <= 8'd0;
            r_sel        <= 2'd0;
            r_cin        <= 1'b0;
            r_id         <= 1'b0;
            r_sh_source  <= 32'd0;
            r_sh_amount  <= 5'd0;
            r_sh_sel     <= 2'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_carry  <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_src       <= w_in_src;
                        r_amt       <= w_in_amt;
                        r_sel       <= w_in_sel;
                        r_cin       <= w_in_cin;
                        r_id        <= w_grant;
                        r_sh_source <= w_in_src;
                        r_sh_sel    <= w_in_sel;
                        r_sh_amount <= w_in_override ? 5'd0 : w_in_amt[4:0];
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= w_fix_result;
                    r_rsp_carry  <= w_fix_carry;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr        <= ~r_rsp_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sh_source  = r_sh_source;
    assign sh_amount  = r_sh_amount;
    assign sh_sel     = r_sh_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_id     = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Directed self-checking bench for shift_arbiter with a purely
//               logical barrel-shifter model on the sh_* port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_src = '0, req1_src = '0;
    logic [7:0]  req0_amt = '0, req1_amt = '0;
    logic [1:0]  req0_sel = '0, req1_sel = '0;
    logic        req0_cin = 1'b0, req1_cin = 1'b0;
    logic [31:0] sh_source;
    logic [4:0]  sh_amount;
    logic [1:0]  sh_sel;
    logic [31:0] sh_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_id;

    int n_checks = 0;
    int n_fail   = 0;

    shift_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src(req0_src),
        .req0_amt(req0_amt), .req0_sel(req0_sel), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src(req1_src),
        .req1_amt(req1_amt), .req1_sel(req1_sel), .req1_cin(req1_cin),
        .sh_source(sh_source), .sh_amount(sh_amount), .sh_sel(sh_sel),
        .sh_result(sh_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    // Logical shifter: ASR behaves as LSR, the DUT adds the sign fill.
    always_comb begin
        case (sh_sel)
            2'b00:   sh_result = sh_source << sh_amount;
            2'b11:   sh_result = (sh_amount == 5'd0) ? sh_source :
                                 ((sh_source >> sh_amount) | (sh_source << (6'd32 - {1'b0, sh_amount})));
            default: sh_result = sh_source >> sh_amount;
        endcase
    end

    task automatic set_req(input bit port, input bit v, input logic [31:0] s,
                           input logic [7:0] a, input logic [1:0] sel, input bit c);
        if (port) begin
            req1_valid = v; req1_src = s; req1_amt = a; req1_sel = sel; req1_cin = c;
        end else begin
            req0_valid = v; req0_src = s; req0_amt = a; req0_sel = sel; req0_cin = c;
        end
    endtask

    task automatic run_op(input string name, input bit port, input logic [31:0] s,
                          input logic [7:0] a, input logic [1:0] sel, input bit c,
                          input logic [31:0] exp_res, input bit exp_c);
        @(negedge clk);
        set_req(port, 1'b1, s, a, sel, c);
        #1;
        n_checks++;
        if ((port ? req1_ready : req0_ready) !== 1'b1) begin
            n_fail++; $display("FAIL %s ready: got %b want 1", name, port ? req1_ready : req0_ready);
        end
        @(negedge clk);
        set_req(port, 1'b0, 32'd0, 8'd0, 2'd0, 1'b0);
        n_checks++;
        if (rsp_valid !== 1'b0 || sh_source !== s) begin
            n_fail++; $display("FAIL %s exec: rsp_valid %b sh_source %h want 0 %h", name, rsp_valid, sh_source, s);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_carry !== exp_c || rsp_id !== port) begin
            n_fail++;
            $display("FAIL %s rsp: valid %b result %h carry %b id %b want 1 %h %b %b",
                     name, rsp_valid, rsp_result, rsp_carry, rsp_id, exp_res, exp_c, port);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s release: rsp_valid %b want 0", name, rsp_valid);
        end
    endtask

    task automatic test_reset;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 ||
            rsp_carry !== 1'b0 || rsp_id !== 1'b0 || sh_source !== 32'd0 || sh_amount !== 5'd0 || sh_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: rdy %b%b rsp %b %h %b %b sh %h %h %h want all 0",
                     req0_ready, req1_ready, rsp_valid, rsp_result, rsp_carry, rsp_id, sh_source, sh_amount, sh_sel);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single;
        run_op("ror1", 1'b0, 32'h8000_0001, 8'd1, 2'b11, 1'b0, 32'hC000_0000, 1'b1);
        run_op("lsr1_p1", 1'b1, 32'h8000_0001, 8'd1, 2'b01, 1'b0, 32'h4000_0000, 1'b1);
        run_op("lsl4", 1'b0, 32'h8000_0001, 8'd4, 2'b00, 1'b1, 32'h0000_0010, 1'b0);
        run_op("lsl31", 1'b1, 32'h8000_0001, 8'd31, 2'b00, 1'b1, 32'h8000_0000, 1'b0);
        run_op("lsr31", 1'b0, 32'h8000_0001, 8'd31, 2'b01, 1'b1, 32'h0000_0001, 1'b0);
        run_op("ror36", 1'b1, 32'h8000_0001, 8'd36, 2'b11, 1'b1, 32'h1800_0000, 1'b0);
    endtask

    task automatic test_boundaries;
        run_op("lsl32", 1'b0, 32'h8000_0001, 8'd32, 2'b00, 1'b0, 32'h0, 1'b1);
        run_op("lsl33", 1'b0, 32'h8000_0001, 8'd33, 2'b00, 1'b1, 32'h0, 1'b0);
        run_op("lsr32", 1'b1, 32'h8000_0001, 8'd32, 2'b01, 1'b0, 32'h0, 1'b1);
        run_op("asr40", 1'b0, 32'h8000_0001, 8'd40, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_op("ror64", 1'b1, 32'h8000_0001, 8'd64, 2'b11, 1'b0, 32'h8000_0001, 1'b1);
    endtask

    task automatic test_sign_fill;
        run_op("asr4", 1'b0, 32'hF000_0000, 8'd4, 2'b10, 1'b1, 32'hFF00_0000, 1'b0);
        for (int k = 0; k < 4; k++)
            run_op("amt0", k[0], 32'h1234_5678, 8'd0, k[1:0], 1'b1, 32'h1234_5678, 1'b1);
    endtask

    task automatic test_contention;
        bit g[$];
        bit ids[$];
        bit exp_seq[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(1'b0, 1'b1, 32'h11, 8'd0, 2'b00, 1'b0);
        set_req(1'b1, 1'b1, 32'h22, 8'd0, 2'b00, 1'b0);
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && ids.size() < 4; cyc++) begin
            #1;
            if (req0_ready && req1_ready) begin
                n_checks++; n_fail++; $display("FAIL contention both_ready: got 11 want one-hot");
            end
            if (req0_ready) g.push_back(1'b0);
            if (req1_ready) g.push_back(1'b1);
            if (rsp_valid) begin
                ids.push_back(rsp_id);
                n_checks++;
                if (rsp_result !== (rsp_id ? 32'h22 : 32'h11)) begin
                    n_fail++; $display("FAIL contention data: got %h for id %b", rsp_result, rsp_id);
                end
            end
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 32'd0, 8'd0, 2'd0, 1'b0);
        set_req(1'b1, 1'b0, 32'd0, 8'd0, 2'd0, 1'b0);
        rsp_ready = 1'b0;
        n_checks++;
        if (ids.size() != 4) begin
            n_fail++; $display("FAIL contention count: got %0d responses want 4", ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (g[i] !== exp_seq[i] || ids[i] !== exp_seq[i]) begin
                    n_fail++; $display("FAIL contention order[%0d]: grant %b id %b want %b", i, g[i], ids[i], exp_seq[i]);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_req(1'b1, 1'b1, 32'h8000_0001, 8'd1, 2'b01, 1'b0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'd0, 8'd0, 2'd0, 1'b0);
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h4000_0000 || rsp_carry !== 1'b1 || rsp_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure hold[%0d]: v %b r %h c %b id %b rdy %b%b want 1 40000000 1 1 00",
                         i, rsp_valid, rsp_result, rsp_carry, rsp_id, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL backpressure extra[%0d]: rsp_valid %b want 0", i, rsp_valid);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'hF000_0000, 8'd4, 2'b10, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 8'd0, 2'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid idle: rsp_valid %b req1_ready %b want 0 1", rsp_valid, req1_ready);
        end
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid ghost[%0d]: rsp_valid %b want 0", i, rsp_valid);
            end
        end
        rsp_ready = 1'b0;
        run_op("after_reset", 1'b0, 32'hF000_0000, 8'd4, 2'b10, 1'b0, 32'hFF00_0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_sign_fill();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
